// File: rtl/maf_issue_sched.sv
// maf_issue_sched: two-requester MAF issue scheduler with packed pairing (MAF_PAIR_EN), class-switch bubbles, credit-tracked completions.
// Latency: accept -> issue_valid 1 cycle; accept -> done_valid LATENCY+1 cycles through an empty completion FIFO.
// Backpressure: grants stall at zero credit; credit returns on each completion pop (done_valid && done_ready).

module maf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         head_vld,
    output logic [W-1:0] head_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign do_pop   = pop_rdy && head_vld;

    // Head is read combinationally, so push+pop on a full FIFO is safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_vld} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

module maf_issue_sched #(
    parameter int TAG_W      = 4,
    parameter int LATENCY    = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int SWITCH_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_cont,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_cont,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             issue_valid,
    output logic [2:0]       cont,
    output logic [1:0]       issue_mask,
    output logic [TAG_W-1:0] issue_tag0,
    output logic [TAG_W-1:0] issue_tag1,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [1:0]       done_mask,
    output logic [TAG_W-1:0] done_tag0,
    output logic [TAG_W-1:0] done_tag1,
    output logic             busy
);
    typedef struct packed {
        logic [1:0]       mask;
        logic [TAG_W-1:0] tag0;
        logic [TAG_W-1:0] tag1;
    } op_t;

    typedef enum logic {RUN = 1'b0, SWITCH = 1'b1} state_t;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = $clog2(SWITCH_GAP + 1);

    state_t            state_q, state_d;
    logic [GW-1:0]     gap_q;
    logic              last_class_q;   // 1 = packed
    logic              rr_q;
    logic [CW-1:0]     credit_q;
    logic [LATENCY-1:0] pv_q;
    op_t               pipe_q [LATENCY];
    logic [2:0]        cont_q;
    logic              busy_q;

    logic cls0, cls1, pipe_empty, cand0, cand1, pick1, chosen_cls;
    logic g0, g1, pair, do_switch, accept, pair_ok, pop, head_vld;
    op_t        issue_d, head_dat;
    logic [2:0] cont_d;

    function automatic logic is_packed(input logic [2:0] c);
        return !((c == 3'b000) || (c == 3'b010));
    endfunction

    assign cls0       = is_packed(req0_cont);
    assign cls1       = is_packed(req1_cont);
    assign pipe_empty = (pv_q == '0);
    assign cand0      = req0_valid && ((cls0 == last_class_q) || pipe_empty);
    assign cand1      = req1_valid && ((cls1 == last_class_q) || pipe_empty);
    assign pick1      = cand1 && (!cand0 || rr_q);
    assign chosen_cls = pick1 ? cls1 : cls0;

    always_comb begin
        pair_ok = 1'b0;
`ifdef MAF_PAIR_EN
        pair_ok = req0_valid && req1_valid && cls0 && cls1 && (req0_cont == req1_cont);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            gap_q        <= '0;
            last_class_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_switch) begin
                gap_q        <= GW'(SWITCH_GAP);
                last_class_q <= chosen_cls;
            end else if (state_q == SWITCH) begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (do_switch) state_d = SWITCH;
            SWITCH:  if (gap_q <= GW'(1)) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        g0        = 1'b0;
        g1        = 1'b0;
        pair      = 1'b0;
        do_switch = 1'b0;
        if (!rst && (state_q == RUN) && (cand0 || cand1)) begin
            if (chosen_cls != last_class_q) begin
                do_switch = 1'b1;
            end else if (credit_q != '0) begin
                if (pair_ok) begin
                    pair = 1'b1;
                    g0   = 1'b1;
                    g1   = 1'b1;
                end else if (pick1) begin
                    g1 = 1'b1;
                end else begin
                    g0 = 1'b1;
                end
            end
        end
    end

    assign req0_ready = g0;
    assign req1_ready = g1;
    assign accept     = g0 || g1;

    always_comb begin
        issue_d = '0;
        cont_d  = '0;
        if (pair) begin
            issue_d.mask = 2'b11;
            issue_d.tag0 = req0_tag;
            issue_d.tag1 = req1_tag;
            cont_d       = req0_cont;
        end else if (accept) begin
            issue_d.mask = chosen_cls ? 2'b01 : 2'b11;
            issue_d.tag0 = g1 ? req1_tag : req0_tag;
            cont_d       = g1 ? req1_cont : req0_cont;
        end
    end

    // Stage 0 of the pipe doubles as the registered issue outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q     <= '0;
            cont_q   <= '0;
            rr_q     <= 1'b0;
            credit_q <= CW'(FIFO_DEPTH);
            busy_q   <= 1'b0;
            for (int k = 0; k < LATENCY; k++) pipe_q[k] <= '0;
        end else begin
            pv_q[0]   <= accept;
            pipe_q[0] <= issue_d;
            cont_q    <= cont_d;
            for (int k = 1; k < LATENCY; k++) begin
                pv_q[k]   <= pv_q[k-1];
                pipe_q[k] <= pipe_q[k-1];
            end
            rr_q     <= rr_q ^ (accept && !pair);
            credit_q <= credit_q - CW'(accept) + CW'(pop);
            busy_q   <= !pipe_empty || head_vld || (state_q == SWITCH);
        end
    end

    maf_fifo #(.W($bits(op_t)), .DEPTH(FIFO_DEPTH)) u_done_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (pv_q[LATENCY-1]),
        .push_dat (pipe_q[LATENCY-1]),
        .pop_rdy  (done_ready),
        .head_vld (head_vld),
        .head_dat (head_dat)
    );

    assign pop         = head_vld && done_ready;
    assign issue_valid = pv_q[0];
    assign cont        = cont_q;
    assign issue_mask  = pipe_q[0].mask;
    assign issue_tag0  = pipe_q[0].tag0;
    assign issue_tag1  = pipe_q[0].tag1;
    assign done_valid  = head_vld;
    assign done_mask   = head_vld ? head_dat.mask : '0;
    assign done_tag0   = head_vld ? head_dat.tag0 : '0;
    assign done_tag1   = head_vld ? head_dat.tag1 : '0;
    assign busy        = busy_q;
endmodule

// File: tb/tb_maf_issue_sched.sv
// Bench for maf_issue_sched: directed scenarios plus random traffic against a queue-based reference model.
module tb_maf_issue_sched;
    localparam int TAG_W = 4;
    localparam int LAT   = 6;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
`ifdef MAF_PAIR_EN
    localparam bit PAIR = 1'b1;
`else
    localparam bit PAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_cont, req1_cont, cont;
    logic [TAG_W-1:0] req0_tag, req1_tag, issue_tag0, issue_tag1, done_tag0, done_tag1;
    logic issue_valid, done_valid, done_ready, busy;
    logic [1:0] issue_mask, done_mask;

    always #5 clk = ~clk;

    maf_issue_sched #(.TAG_W(TAG_W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .SWITCH_GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cont(req0_cont), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cont(req1_cont), .req1_tag(req1_tag),
        .issue_valid(issue_valid), .cont(cont), .issue_mask(issue_mask),
        .issue_tag0(issue_tag0), .issue_tag1(issue_tag1),
        .done_valid(done_valid), .done_ready(done_ready), .done_mask(done_mask),
        .done_tag0(done_tag0), .done_tag1(done_tag1), .busy(busy)
    );

    typedef struct {
        logic [1:0]       mask;
        logic [TAG_W-1:0] t0;
        logic [TAG_W-1:0] t1;
        int               a;
    } op_t;

    op_t inflight[$];
    op_t fq[$];
    bit m_iv, m_busy, m_last, m_rr, g0, g1;
    logic [2:0] m_cont;
    logic [1:0] m_mask;
    logic [TAG_W-1:0] m_t0, m_t1;
    int m_gap, cyc, acc;
    int checks = 0;
    int errors = 0;

    function automatic bit pk(input logic [2:0] c);
        return !((c == 3'b000) || (c == 3'b010));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        fq.delete();
        m_iv = 0; m_busy = 0; m_last = 0; m_rr = 0; m_gap = 0;
        m_cont = '0; m_mask = '0; m_t0 = '0; m_t1 = '0;
    endtask

    // One clock cycle: check registered outputs and grants, then advance the model.
    task automatic step();
        bit c0, c1, pick1, chpk, sw, pair, pop, start_busy;
        int credit;
        op_t nop;
        logic [2:0] ncont;
        #1;
        chk("issue_valid", issue_valid, m_iv);
        if (m_iv) begin
            chk("cont", cont, m_cont);
            chk("issue_mask", issue_mask, m_mask);
            chk("issue_tag0", issue_tag0, m_t0);
            chk("issue_tag1", issue_tag1, m_t1);
        end
        chk("done_valid", done_valid, fq.size() != 0);
        if (fq.size() != 0) begin
            chk("done_mask", done_mask, fq[0].mask);
            chk("done_tag0", done_tag0, fq[0].t0);
            chk("done_tag1", done_tag1, fq[0].t1);
        end
        chk("busy", busy, m_busy);

        g0 = 0; g1 = 0; sw = 0; pair = 0; chpk = 0;
        credit = DEPTH - inflight.size() - fq.size();
        if (!rst && m_gap == 0) begin
            c0 = req0_valid && (pk(req0_cont) == m_last || inflight.size() == 0);
            c1 = req1_valid && (pk(req1_cont) == m_last || inflight.size() == 0);
            if (c0 || c1) begin
                pick1 = c1 && (!c0 || m_rr);
                chpk  = pick1 ? pk(req1_cont) : pk(req0_cont);
                if (chpk != m_last) sw = 1;
                else if (credit > 0) begin
                    if (PAIR && req0_valid && req1_valid && pk(req0_cont) && pk(req1_cont)
                        && req0_cont == req1_cont) begin
                        pair = 1; g0 = 1; g1 = 1;
                    end else if (pick1) g1 = 1;
                    else g0 = 1;
                end
            end
        end
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        acc += int'(req0_ready && req0_valid) + int'(req1_ready && req1_valid);

        nop.a = cyc;
        nop.t1 = '0;
        if (pair) begin
            nop.mask = 2'b11; nop.t0 = req0_tag; nop.t1 = req1_tag; ncont = req0_cont;
        end else begin
            nop.t0 = g1 ? req1_tag : req0_tag;
            ncont  = g1 ? req1_cont : req0_cont;
            nop.mask = pk(ncont) ? 2'b01 : 2'b11;
        end
        pop = !rst && fq.size() != 0 && done_ready;
        start_busy = inflight.size() != 0 || fq.size() != 0 || m_gap > 0;

        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (pop) void'(fq.pop_front());
            while (inflight.size() != 0 && inflight[0].a + LAT == cyc) fq.push_back(inflight.pop_front());
            m_busy = start_busy;
            m_iv = g0 || g1;
            if (m_iv) begin
                inflight.push_back(nop);
                m_cont = ncont; m_mask = nop.mask; m_t0 = nop.t0; m_t1 = nop.t1;
            end
            if (m_gap > 0) m_gap--;
            else if (sw) begin m_gap = GAP; m_last = chpk; end
            if (m_iv && !pair) m_rr = !m_rr;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic rearm(input bit keep);
        if (g0) begin if (keep) req0_tag = req0_tag + 1'b1; else req0_valid = 0; end
        if (g1) begin if (keep) req1_tag = req1_tag + 1'b1; else req1_valid = 0; end
    endtask

    task automatic run(input int n, input bit keep);
        repeat (n) begin step(); rearm(keep); end
    endtask

    task automatic chk_idle(input string p);
        #1;
        chk({p, "_issue_valid"}, issue_valid, 0);
        chk({p, "_cont"}, cont, 0);
        chk({p, "_issue_mask"}, issue_mask, 0);
        chk({p, "_issue_tags"}, {issue_tag0, issue_tag1}, 0);
        chk({p, "_done_valid"}, done_valid, 0);
        chk({p, "_done_fields"}, {done_mask, done_tag0, done_tag1}, 0);
        chk({p, "_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1; req0_valid = 0; req1_valid = 0; done_ready = 1;
        req0_cont = '0; req1_cont = '0; req0_tag = '0; req1_tag = '0;
        cyc = 0; acc = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 0;
        chk_idle("reset");

        // Lone wide op through to completion
        req0_valid = 1; req0_cont = 3'b000; req0_tag = 4'd3;
        run(12, 0);

        // Two matching packed ops (paired or serialized depending on build)
        req0_valid = 1; req0_cont = 3'b001; req0_tag = 4'd5;
        req1_valid = 1; req1_cont = 3'b001; req1_tag = 4'd9;
        run(16, 0);

        // Wide op, then a packed op arriving while the wide op is in flight
        req0_valid = 1; req0_cont = 3'b010; req0_tag = 4'd1;
        run(4, 0);
        req1_valid = 1; req1_cont = 3'b011; req1_tag = 4'd2;
        run(20, 0);

        // Credit exhaustion with a stalled consumer, then a single pop
        req0_valid = 1; req0_cont = 3'b000; req0_tag = 4'd0;
        req1_valid = 1; req1_cont = 3'b010; req1_tag = 4'd8;
        done_ready = 0; acc = 0;
        run(16, 1);
        chk("stall_accepts", acc, 4);
        done_ready = 1; acc = 0;
        step(); rearm(1);
        done_ready = 0;
        run(8, 1);
        chk("extra_accepts", acc, 1);

        // Continuous wide traffic on both ports
        done_ready = 1;
        run(10, 1);

        // Reset with ops in flight
        rst = 1; req0_valid = 0; req1_valid = 0;
        step();
        rst = 0;
        chk_idle("midrst");
        run(12, 0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            done_ready = ($urandom_range(0, 3) != 0);
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1; req0_cont = 3'($urandom_range(0, 7)); req0_tag = 4'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1; req1_tag = 4'($urandom);
                req1_cont = ($urandom_range(0, 2) == 0) ? req0_cont : 3'($urandom_range(0, 7));
            end
            step();
            rearm(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/maf_issue_sched.md
Name: maf_issue_sched

Overview:
- Issue scheduler in front of the MAF datapath and its leading-zero anticipation/revise stages.
- Arbitrates two operation requesters and drives the 3-bit `cont` mode code consumed by the datapath:
  - wide modes: 000, 010
  - packed dual-lane modes: all other codes
- Pairs compatible packed ops into one issue and inserts reconfiguration bubbles on wide/packed switches.
- Tracks in-flight ops through a fixed-latency pipe into a credit-managed completion FIFO.

Parameters:
- `TAG_W`, 4, width of the per-op tag
- `LATENCY`, 6, datapath latency in cycles, issue to result (≥1)
- `FIFO_DEPTH`, 4, completion FIFO entries (power of 2, ≥2)
- `SWITCH_GAP`, 2, idle cycles inserted when the `cont` class changes (≥1)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `req0_valid`  in  1  requester 0 has an op
- `req0_ready`  out  1  requester 0 op accepted this cycle
- `req0_cont`  in  3  requested mode code
- `req0_tag`  in  TAG_W  op tag
- `req1_valid`  in  1  requester 1 has an op
- `req1_ready`  out  1  requester 1 op accepted this cycle
- `req1_cont`  in  3  requested mode code
- `req1_tag`  in  TAG_W  op tag
- `issue_valid`  out  1  datapath issue strobe
- `cont`  out  3  mode code to datapath
- `issue_mask`  out  2  lane occupancy; bit0 = low lane, bit1 = high lane; 2'b11 for wide ops
- `issue_tag0`  out  TAG_W  low-lane / wide op tag
- `issue_tag1`  out  TAG_W  high-lane tag
- `done_valid`  out  1  completion available
- `done_ready`  in  1  consumer accepts completion
- `done_mask`  out  2  lanes completed
- `done_tag0`  out  TAG_W  completion tag, low lane / wide
- `done_tag1`  out  TAG_W  completion tag, high lane
- `busy`  out  1  any op in flight or buffered

Behaviour:

Reset values:
- All outputs are 0 after reset: `issue_valid`, `req*_ready`, `done_valid`, `busy`, `cont`, masks, tags.
- State = RUN, rr pointer = 0, credit = FIFO_DEPTH, `last_class` = wide.
- A reset mid-operation discards all in-flight and buffered ops.

Class and outputs:
- Class of a code: wide if code ∈ {000, 010}, else packed.
- All issue outputs are registered. An accept in cycle N produces `issue_valid` = 1 in cycle N+1, for one cycle per accept.
- `req*_ready` is combinational: the grant in the current cycle.

Credit:
- credit = FIFO_DEPTH − (ops in pipe + FIFO occupancy), counted per issue, not per lane.
- No grant when credit = 0.
- Credit decrements on accept and increments on a FIFO pop.
- Simultaneous accept and pop leaves credit unchanged.

State machine:
- RUN:
  - Candidates are the valid requesters whose class equals `last_class`, or any valid requester if nothing is in the pipe.
  - If the chosen op's class ≠ `last_class`: grant nothing, load the gap counter with SWITCH_GAP, set `last_class` to the new class, go to SWITCH.
- SWITCH:
  - Counter decrements each cycle; no grants.
  - Returns to RUN when the counter reaches 1.
  - Requests that change during SWITCH are re-evaluated in RUN.

Grant rules in RUN:
- Pairing: both valid, both packed, identical codes, credit ≥ 1 → accept both in the same cycle.
  - Issue `issue_mask` = 11, `issue_tag0` = req0_tag, `issue_tag1` = req1_tag.
  - rr pointer unchanged.
- Otherwise single grant to the rr-preferred valid candidate; rr toggles after each single grant.
  - Wide op: `issue_mask` = 11, `issue_tag1` = 0.
  - Packed op: `issue_mask` = 01, lane0 only.

Pipe and completion:
- LATENCY-deep shift register carrying {valid, mask, tag0, tag1}.
- Entry exiting the pipe is pushed into the FIFO. Overflow is impossible by credit.
- FIFO head drives the `done_*` outputs; pop when `done_valid` && `done_ready`.
- Push to an empty FIFO: `done_valid` rises the next cycle.
- Push and pop in the same cycle are both honoured, including when the FIFO is full with a pop.

Busy:
- `busy` = pipe non-empty | FIFO non-empty | state == SWITCH, registered.

Optional Feature:
- Macro: `MAF_PAIR_EN`.
- Defined: packed-op pairing as described above.
- Undefined:
  - No pairing; packed ops always issue singly with `issue_mask` = 01.
  - Pairing logic is not compiled; all other behaviour is identical.

Test Plan:
1. Reset, then req0 wide (cont=000, tag=3) alone → `req0_ready` = 1 in cycle 0; `issue_valid` = 1, `cont` = 000, mask = 11, tag0 = 3 in cycle 1; `done_valid` with tag0 = 3 in cycle 1+LATENCY.
2. With `MAF_PAIR_EN`, both requesters issue packed cont=001, tags 5 and 9, in the same cycle → both ready; single issue with mask = 11, tag0 = 5, tag1 = 9. Without the macro → two issues on consecutive cycles, each with mask = 01.
3. Wide op, then packed op requested while the wide op is still in the pipe → packed op held until the pipe is empty; then 2 idle cycles (SWITCH_GAP = 2); then the packed issue.
4. `done_ready` = 0 with FIFO_DEPTH = 4 and continuous wide requests → exactly 4 accepts, then `req*_ready` stays 0. Raise `done_ready` for one cycle → exactly one additional accept.
5. Both requesters wide and continuously valid → grants alternate 0, 1, 0, 1 in consecutive cycles.
6. Assert `rst` with 3 ops in flight → next cycle all outputs 0 and credit = 4; no stale `done_valid` afterwards.
